// File: rtl/res_station_age_pkg.sv
// Shared types for the age-ordered reservation station.
//  rename_data : renamed op as delivered by dispatch
//  rs_data     : op as held in the station and issued to the FU (adds rob_index)
//  rob_age()   : distance of a ROB index from the ROB head (smaller = older)
package res_station_age_pkg;

  localparam int RS_ROB_W  = 5;
  localparam int RS_PREG_W = 7;
  localparam int RS_N_PREG = 1 << RS_PREG_W;

  typedef struct packed {
    logic [1:0]           fu;
    logic [6:0]           opcode;
    logic [RS_PREG_W-1:0] pd_new;
    logic [RS_PREG_W-1:0] ps1;
    logic [RS_PREG_W-1:0] ps2;
    logic [31:0]          imm;
    logic [2:0]           func3;
    logic [6:0]           func7;
  } rename_data;

  typedef struct packed {
    rename_data          op;
    logic [RS_ROB_W-1:0] rob_index;
  } rs_data;

  // Modular subtraction: the head itself is age 0, wrap-around is implicit.
  function automatic logic [RS_ROB_W-1:0] rob_age(input logic [RS_ROB_W-1:0] idx,
                                                  input logic [RS_ROB_W-1:0] head);
    return idx - head;
  endfunction

endpackage

// File: rtl/res_station_age_if.sv
// Bundle of all non-clock/reset signals of the reservation station.
//  master : dispatch / wakeup / flush / FU side driving the station
//  slave  : the station itself (issue_valid, data_out, full, count outputs)
interface res_station_age_if import res_station_age_pkg::*; #(
  parameter int DEPTH  = 8,
  parameter int N_WAKE = 2,
  parameter int PREG_W = RS_PREG_W,
  parameter int ROB_W  = RS_ROB_W,
  parameter int N_PREG = RS_N_PREG
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                           di_en;
  rename_data                     r_data;
  logic [ROB_W-1:0]               rob_index_in;
  logic [N_PREG-1:0]              preg_rtable;
  logic [N_WAKE-1:0]              wake_valid;
  logic [N_WAKE-1:0][PREG_W-1:0]  wake_tag;
  logic                           fu_ready;
  logic [ROB_W-1:0]               rob_head;
  logic                           flush;
  logic [ROB_W-1:0]               flush_tag;
  logic                           issue_valid;
  rs_data                         data_out;
  logic                           full;
  logic [CNT_W-1:0]               count;

  modport master (
    output di_en, r_data, rob_index_in, preg_rtable, wake_valid, wake_tag,
           fu_ready, rob_head, flush, flush_tag,
    input  issue_valid, data_out, full, count
  );

  modport slave (
    input  di_en, r_data, rob_index_in, preg_rtable, wake_valid, wake_tag,
           fu_ready, rob_head, flush, flush_tag,
    output issue_valid, data_out, full, count
  );

endinterface

// File: rtl/res_station_age_oldest_picker.sv
// Oldest-eligible selector: binary tree of age comparators.
//  eligible    in  per-entry candidate mask
//  rob_index   in  per-entry ROB index
//  rob_head    in  age origin
//  grant_valid out at least one candidate
//  grant_idx   out entry holding the smallest age among candidates
// DEPTH need not be a power of two; missing leaves are tied off as invalid.
module rs_oldest_picker #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 5
) (
  input  logic [DEPTH-1:0]            eligible,
  input  logic [DEPTH-1:0][ROB_W-1:0] rob_index,
  input  logic [ROB_W-1:0]            rob_head,
  output logic                        grant_valid,
  output logic [$clog2(DEPTH)-1:0]    grant_idx
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LEAVES = 1 << IDX_W;

  // Heap layout: node n has children 2n and 2n+1, leaves at LEAVES..2*LEAVES-1.
  logic             nv [2*LEAVES-1:1];
  logic [IDX_W-1:0] ni [2*LEAVES-1:1];
  logic [ROB_W-1:0] na [2*LEAVES-1:1];
  logic             take_right;

  always_comb begin
    take_right = 1'b0;
    for (int n = 1; n < 2*LEAVES; n++) begin
      nv[n] = 1'b0;
      ni[n] = '0;
      na[n] = '0;
    end
    for (int l = 0; l < DEPTH; l++) begin
      nv[LEAVES+l] = eligible[l];
      ni[LEAVES+l] = IDX_W'(l);
      na[LEAVES+l] = ROB_W'(rob_index[l] - rob_head);
    end
    // Children are always resolved before their parent (descending order).
    for (int n = LEAVES-1; n >= 1; n--) begin
      take_right = nv[2*n+1] && (!nv[2*n] || (na[2*n+1] < na[2*n]));
      nv[n] = nv[2*n] || nv[2*n+1];
      ni[n] = take_right ? ni[2*n+1] : ni[2*n];
      na[n] = take_right ? na[2*n+1] : na[2*n];
    end
    grant_valid = nv[1];
    grant_idx   = ni[1];
  end

endmodule

// File: rtl/res_station_age.sv
// Age-ordered reservation station between dispatch and one functional unit.
//  clk, reset : clock, synchronous active-high reset
//  bus (slave): dispatch (di_en, r_data, rob_index_in, preg_rtable),
//               wakeup (wake_valid, wake_tag), issue (fu_ready, issue_valid,
//               data_out), age origin (rob_head), flush (flush, flush_tag),
//               status (full, count)
// Ops wait for both source tags, then the oldest ready op (by ROB age) issues.
// A flush removes every op younger than the mispredicted branch.
module res_station_age import res_station_age_pkg::*; #(
  parameter int DEPTH  = 8,
  parameter int N_WAKE = 2,
  parameter int PREG_W = RS_PREG_W,
  parameter int ROB_W  = RS_ROB_W,
  parameter int N_PREG = RS_N_PREG
) (
  input logic              clk,
  input logic              reset,
  res_station_age_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  rs_data                      ent [DEPTH];
  logic [DEPTH-1:0]            valid, rdy1, rdy2;
  logic [DEPTH-1:0]            wake1, wake2, killed, eligible;
  logic [DEPTH-1:0][ROB_W-1:0] ent_rob;
  logic [N_PREG-1:0]           rtable;
  logic [ROB_W-1:0]            flush_age;
  logic                        grant_valid, do_issue;
  logic [IDX_W-1:0]            grant_idx, free_idx;
  logic                        free_found, alloc, in_rdy1, in_rdy2;
  logic [CNT_W-1:0]            kill_cnt;

  function automatic logic tag_hit(input logic [PREG_W-1:0]             tag,
                                   input logic [N_WAKE-1:0]             wv,
                                   input logic [N_WAKE-1:0][PREG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < N_WAKE; p++) hit = hit | (wv[p] && (wt[p] == tag));
    return hit;
  endfunction

  assign rtable    = bus.preg_rtable;
  assign flush_age = rob_age(bus.flush_tag, bus.rob_head);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_rob[i]  = ent[i].rob_index;
      wake1[i]    = tag_hit(ent[i].op.ps1, bus.wake_valid, bus.wake_tag);
      wake2[i]    = tag_hit(ent[i].op.ps2, bus.wake_valid, bus.wake_tag);
      // Strictly younger than the branch; the branch itself survives.
      killed[i]   = bus.flush && valid[i] &&
                    (rob_age(ent[i].rob_index, bus.rob_head) > flush_age);
      eligible[i] = valid[i] && rdy1[i] && rdy2[i] && !killed[i];
    end
  end

  // Lowest-index free entry, from pre-edge occupancy only.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    kill_cnt = '0;
    for (int i = 0; i < DEPTH; i++) kill_cnt = kill_cnt + CNT_W'(killed[i]);
  end

  rs_oldest_picker #(.DEPTH(DEPTH), .ROB_W(ROB_W)) u_picker (
    .eligible    (eligible),
    .rob_index   (ent_rob),
    .rob_head    (bus.rob_head),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Same-cycle wake on a source tag bypasses into the new entry.
  assign in_rdy1  = rtable[bus.r_data.ps1] || tag_hit(bus.r_data.ps1, bus.wake_valid, bus.wake_tag);
  assign in_rdy2  = rtable[bus.r_data.ps2] || tag_hit(bus.r_data.ps2, bus.wake_valid, bus.wake_tag);
  assign alloc    = bus.di_en && !bus.full && !bus.flush && free_found;
  assign do_issue = bus.fu_ready && grant_valid;
  assign bus.full = (bus.count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      valid           <= '0;
      bus.issue_valid <= 1'b0;
      bus.data_out    <= '0;
      bus.count       <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc && (free_idx == IDX_W'(i))) begin
          valid[i] <= 1'b1;
          ent[i]   <= '{op: bus.r_data, rob_index: bus.rob_index_in};
          rdy1[i]  <= in_rdy1;
          rdy2[i]  <= in_rdy2;
        end else begin
          if (killed[i] || (do_issue && (grant_idx == IDX_W'(i)))) valid[i] <= 1'b0;
          if (wake1[i]) rdy1[i] <= 1'b1;
          if (wake2[i]) rdy2[i] <= 1'b1;
        end
      end
      bus.issue_valid <= do_issue;
      if (do_issue) bus.data_out <= ent[grant_idx];
      // Killed and issued sets are disjoint, so the terms never double count.
      bus.count <= bus.count + CNT_W'(alloc) - CNT_W'(do_issue) - kill_cnt;
    end
  end

endmodule

// File: tb/tb_res_station_age.sv
module tb_res_station_age;
  import res_station_age_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  res_station_age_if #(.DEPTH(DEPTH)) bus ();

  res_station_age #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int drop_seen = 0;

  // Dispatch attempted while the station reports full: the op is lost.
  always @(posedge clk) begin
    if (!reset && bus.di_en && bus.full && !bus.flush) begin
      drop_seen++;
      if (drop_seen <= 3) $display("[TB] note: dispatch of rob %0d dropped while full", bus.rob_index_in);
    end
  end

  // ---------------- reference model: a set of waiting ops ----------------
  typedef struct {
    rename_data d;
    logic [4:0] rob;
    bit         r1;
    bit         r2;
  } mop_t;

  mop_t   q[$];
  bit     exp_iv;
  rs_data exp_do;
  int     exp_cnt;
  bit     last_alloc;

  function automatic bit woke(input logic [6:0] t);
    bit h = 0;
    for (int p = 0; p < 2; p++) if (bus.wake_valid[p] && bus.wake_tag[p] == t) h = 1;
    return h;
  endfunction

  task automatic model_step();
    mop_t nq[$];
    mop_t m;
    int best;
    logic [4:0] a, best_age, fage;
    if (reset) begin
      q.delete(); exp_iv = 0; exp_do = '0; exp_cnt = 0; last_alloc = 0;
      return;
    end
    fage = bus.flush_tag - bus.rob_head;
    best = -1; best_age = '0;
    foreach (q[i]) begin
      a = q[i].rob - bus.rob_head;
      if (!(bus.flush && a > fage) && q[i].r1 && q[i].r2 && (best < 0 || a < best_age)) begin
        best = i; best_age = a;
      end
    end
    if (!bus.fu_ready) best = -1;
    exp_iv = (best >= 0);
    if (best >= 0) exp_do = '{op: q[best].d, rob_index: q[best].rob};
    foreach (q[i]) begin
      a = q[i].rob - bus.rob_head;
      if (!(bus.flush && a > fage) && i != best) begin
        m = q[i];
        m.r1 = m.r1 | woke(m.d.ps1);
        m.r2 = m.r2 | woke(m.d.ps2);
        nq.push_back(m);
      end
    end
    last_alloc = bus.di_en && !bus.flush && q.size() < DEPTH;
    if (last_alloc) begin
      m.d = bus.r_data; m.rob = bus.rob_index_in;
      m.r1 = bus.preg_rtable[bus.r_data.ps1] | woke(bus.r_data.ps1);
      m.r2 = bus.preg_rtable[bus.r_data.ps2] | woke(bus.r_data.ps2);
      nq.push_back(m);
    end
    q = nq;
    exp_cnt = q.size();
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.di_en = 0; bus.r_data = '0; bus.rob_index_in = '0;
    bus.wake_valid = '0; bus.wake_tag = '0; bus.fu_ready = 0;
    bus.flush = 0; bus.flush_tag = '0;
  endtask

  task automatic disp(input logic [4:0] rob, input logic [6:0] pd, input logic [6:0] ps1, input logic [6:0] ps2);
    bus.di_en = 1; bus.rob_index_in = rob;
    bus.r_data.fu = 2'(rob); bus.r_data.opcode = 7'h33; bus.r_data.pd_new = pd;
    bus.r_data.ps1 = ps1; bus.r_data.ps2 = ps2; bus.r_data.imm = $urandom;
    bus.r_data.func3 = 3'(pd); bus.r_data.func7 = 7'(ps2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1; idle(); bus.rob_head = '0; bus.preg_rtable = '1;
    tick(); tick(); reset = 0;
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iv got %b want 0", bus.issue_valid); end
    n_tests++; if (bus.data_out !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.data_out); end
    n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", bus.full); end
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
  endtask

  task automatic test_basic();
    idle(); disp(5'd0, 7'd20, 7'd3, 7'd4); bus.fu_ready = 1; tick();
    n_tests++; if (bus.count !== 4'd1 || bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL basic_alloc count %0d iv %b want 1 0", bus.count, bus.issue_valid); end
    idle(); bus.fu_ready = 1; tick();
    n_tests++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL basic_issue iv %b want 1", bus.issue_valid); end
    n_tests++; if (bus.data_out.op.pd_new !== 7'd20 || bus.data_out.rob_index !== 5'd0) begin n_fail++; $display("FAIL basic_echo pd %0d rob %0d want 20 0", bus.data_out.op.pd_new, bus.data_out.rob_index); end
    n_tests++; if (bus.data_out !== exp_do) begin n_fail++; $display("FAIL basic_data got %h want %h", bus.data_out, exp_do); end
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL basic_count got %0d want 0", bus.count); end
    idle(); tick();
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse iv %b want 0", bus.issue_valid); end
  endtask

  task automatic test_wakeup();
    idle(); bus.preg_rtable[10] = 1'b0; disp(5'd7, 7'd21, 7'd10, 7'd11); tick();
    idle(); disp(5'd5, 7'd22, 7'd1, 7'd2); bus.wake_valid = 2'b10; bus.wake_tag[1] = 7'd10; bus.fu_ready = 1; tick();
    n_tests++; if (bus.issue_valid !== 1'b0 || bus.count !== 4'd2) begin n_fail++; $display("FAIL wake_wait iv %b count %0d want 0 2", bus.issue_valid, bus.count); end
    idle(); bus.fu_ready = 1; tick();
    n_tests++; if (bus.issue_valid !== 1'b1 || bus.data_out.rob_index !== 5'd5) begin n_fail++; $display("FAIL wake_first iv %b rob %0d want 1 5", bus.issue_valid, bus.data_out.rob_index); end
    tick();
    n_tests++; if (bus.issue_valid !== 1'b1 || bus.data_out.rob_index !== 5'd7) begin n_fail++; $display("FAIL wake_second iv %b rob %0d want 1 7", bus.issue_valid, bus.data_out.rob_index); end
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL wake_count got %0d want 0", bus.count); end
    bus.preg_rtable = '1; idle(); tick();
  endtask

  task automatic test_wrap();
    logic [4:0] robs [3];
    logic [4:0] order [3];
    robs[0] = 5'd31; robs[1] = 5'd1; robs[2] = 5'd0;
    order[0] = 5'd31; order[1] = 5'd0; order[2] = 5'd1;
    bus.rob_head = 5'd30;
    for (int i = 0; i < 3; i++) begin idle(); disp(robs[i], 7'(40 + i), 7'd1, 7'd2); tick(); end
    idle(); bus.fu_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (bus.issue_valid !== 1'b1 || bus.data_out.rob_index !== order[i]) begin n_fail++; $display("FAIL wrap_order[%0d] iv %b rob %0d want 1 %0d", i, bus.issue_valid, bus.data_out.rob_index, order[i]); end
    end
    idle(); bus.rob_head = '0; tick();
  endtask

  task automatic test_flush();
    bus.rob_head = 5'd2;
    for (int i = 2; i < 6; i++) begin idle(); disp(5'(i), 7'(50 + i), 7'd1, 7'd2); tick(); end
    n_tests++; if (bus.count !== 4'd4) begin n_fail++; $display("FAIL flush_pre count %0d want 4", bus.count); end
    idle(); disp(5'd6, 7'd60, 7'd1, 7'd2); bus.flush = 1; bus.flush_tag = 5'd3; tick();
    n_tests++; if (bus.count !== 4'd2 || bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill count %0d iv %b want 2 0", bus.count, bus.issue_valid); end
    idle(); bus.fu_ready = 1; tick();
    n_tests++; if (bus.issue_valid !== 1'b1 || bus.data_out.rob_index !== 5'd2) begin n_fail++; $display("FAIL flush_keep0 iv %b rob %0d want 1 2", bus.issue_valid, bus.data_out.rob_index); end
    tick();
    n_tests++; if (bus.issue_valid !== 1'b1 || bus.data_out.rob_index !== 5'd3) begin n_fail++; $display("FAIL flush_keep1 iv %b rob %0d want 1 3", bus.issue_valid, bus.data_out.rob_index); end
    tick();
    n_tests++; if (bus.issue_valid !== 1'b0 || bus.count !== 4'd0) begin n_fail++; $display("FAIL flush_empty iv %b count %0d want 0 0", bus.issue_valid, bus.count); end
    bus.rob_head = '0;
  endtask

  task automatic test_full();
    int d0;
    bus.rob_head = '0;
    for (int i = 0; i < DEPTH; i++) begin idle(); disp(5'(i), 7'(70 + i), 7'd1, 7'd2); tick(); end
    n_tests++; if (bus.full !== 1'b1 || bus.count !== 4'd8) begin n_fail++; $display("FAIL full_set full %b count %0d want 1 8", bus.full, bus.count); end
    d0 = drop_seen;
    idle(); disp(5'd8, 7'd78, 7'd1, 7'd2); tick(); tick();
    n_tests++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL full_hold count %0d want 8", bus.count); end
    n_tests++; if (drop_seen - d0 !== 2) begin n_fail++; $display("FAIL full_drop flagged %0d want 2", drop_seen - d0); end
    bus.fu_ready = 1; tick();
    n_tests++; if (bus.issue_valid !== 1'b1 || bus.data_out.rob_index !== 5'd0 || bus.count !== 4'd7 || bus.full !== 1'b0) begin
      n_fail++; $display("FAIL full_free iv %b rob %0d count %0d full %b want 1 0 7 0", bus.issue_valid, bus.data_out.rob_index, bus.count, bus.full); end
    bus.fu_ready = 0; tick();
    n_tests++; if (bus.count !== 4'd8 || bus.full !== 1'b1) begin n_fail++; $display("FAIL full_reuse count %0d full %b want 8 1", bus.count, bus.full); end
    idle(); bus.fu_ready = 1;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      n_tests++; if (bus.issue_valid !== 1'b1 || bus.data_out.rob_index !== 5'(i)) begin n_fail++; $display("FAIL full_drain[%0d] iv %b rob %0d want 1 %0d", i, bus.issue_valid, bus.data_out.rob_index, i); end
    end
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL full_drain_count got %0d want 0", bus.count); end
    idle(); tick();
  endtask

  task automatic test_bypass();
    idle(); bus.preg_rtable[9] = 1'b0; disp(5'd3, 7'd30, 7'd9, 7'd1);
    bus.wake_valid = 2'b01; bus.wake_tag[0] = 7'd9; bus.fu_ready = 1; tick();
    n_tests++; if (bus.count !== 4'd1 || bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_alloc count %0d iv %b want 1 0", bus.count, bus.issue_valid); end
    idle(); bus.fu_ready = 1; tick();
    n_tests++; if (bus.issue_valid !== 1'b1 || bus.data_out.rob_index !== 5'd3 || bus.count !== 4'd0) begin
      n_fail++; $display("FAIL bypass_issue iv %b rob %0d count %0d want 1 3 0", bus.issue_valid, bus.data_out.rob_index, bus.count); end
    bus.preg_rtable = '1; idle(); tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin idle(); disp(5'(i), 7'(90 + i), 7'd1, 7'd2); tick(); end
    idle(); bus.fu_ready = 1; reset = 1; tick();
    n_tests++; if (bus.issue_valid !== 1'b0 || bus.count !== 4'd0) begin n_fail++; $display("FAIL rstmid_edge iv %b count %0d want 0 0", bus.issue_valid, bus.count); end
    reset = 0; tick();
    n_tests++; if (bus.issue_valid !== 1'b0 || bus.count !== 4'd0) begin n_fail++; $display("FAIL rstmid_after iv %b count %0d want 0 0", bus.issue_valid, bus.count); end
  endtask

  task automatic test_random();
    logic [4:0] rob_next = 5'd11;
    int errs = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      bus.rob_head = (q.size() != 0) ? q[0].rob : rob_next;
      bus.preg_rtable = '1;
      for (int p = 0; p < 16; p++) bus.preg_rtable[p] = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 3) != 0 && 5'(rob_next - bus.rob_head) < 5'd20)
        disp(rob_next, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)));
      for (int p = 0; p < 2; p++) begin
        bus.wake_valid[p] = ($urandom_range(0, 2) == 0);
        bus.wake_tag[p]   = 7'($urandom_range(0, 15));
      end
      bus.fu_ready = ($urandom_range(0, 9) < 6);
      if (q.size() != 0 && $urandom_range(0, 15) == 0) begin
        bus.flush = 1;
        bus.flush_tag = q[$urandom_range(0, q.size() - 1)].rob;
      end
      tick();
      if (last_alloc) rob_next = rob_next + 5'd1;
      n_tests++; if (bus.issue_valid !== exp_iv) begin n_fail++; errs++; if (errs < 10) $display("FAIL rand_iv cyc %0d got %b want %b", cyc, bus.issue_valid, exp_iv); end
      n_tests++; if (bus.data_out !== exp_do) begin n_fail++; errs++; if (errs < 10) $display("FAIL rand_data cyc %0d got %h want %h", cyc, bus.data_out, exp_do); end
      n_tests++; if (bus.count !== 4'(exp_cnt)) begin n_fail++; errs++; if (errs < 10) $display("FAIL rand_count cyc %0d got %0d want %0d", cyc, bus.count, exp_cnt); end
      n_tests++; if (bus.full !== (exp_cnt == DEPTH)) begin n_fail++; errs++; if (errs < 10) $display("FAIL rand_full cyc %0d got %b want %b", cyc, bus.full, exp_cnt == DEPTH); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_wrap();
    test_flush();
    test_full();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
